apb_slave_ws: RTL and testbench

Parametrised APB4 slave front-end for the timer IP register file. It converts tim_* APB transfers into single-cycle register-file strobes, and adds these over the first-generation interface:
- programmable wait states
- byte strobes
- address/alignment checking with PSLVERR
- abort on PSEL drop
It sits between the system APB interconnect and the timer register bank.

---
 rtl/apb_ws_pkg.sv | 21 ++
 rtl/apb_slave_ws_if.sv | 24 ++
 rtl/apb_ws_counter.sv | 21 ++
 rtl/apb_slave_ws.sv | 82 ++++++++
 tb/tb_apb_slave_ws.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_ws_pkg.sv
// Shared encodings and address checking for the timer APB slave front-end.
package apb_ws_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  // Bad if misaligned for the bus width or past the last register.
  function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] max,
                                    input int unsigned data_w = 32);
    logic mis;
    case (data_w)
      32:      mis = (addr[1:0] != 2'b00);
      16:      mis = addr[0];
      default: mis = 1'b0;
    endcase
    return mis | (addr > max);
  endfunction
endpackage

// File: rtl/apb_slave_ws_if.sv
// APB4 completer-side bus bundle for the timer register file.
interface apb_slave_ws_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic                  tim_psel;
  logic                  tim_penable;
  logic                  tim_pwrite;
  logic [ADDR_W-1:0]     tim_paddr;
  logic [DATA_W-1:0]     tim_pwdata;
  logic [DATA_W/8-1:0]   tim_pstrb;
  logic                  tim_pready;
  logic                  tim_pslverr;
  logic [DATA_W-1:0]     tim_prdata;

  modport master (
    output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    input  tim_pready, tim_pslverr, tim_prdata
  );
  modport slave (
    input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
    output tim_pready, tim_pslverr, tim_prdata
  );
endinterface

// File: rtl/apb_ws_counter.sv
// Loadable wait-state down-counter; saturates at zero instead of wrapping.
module apb_ws_counter #(
  parameter int WAIT_CYC = 0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic load,
  input  logic dec,
  output logic zero   // the pending decrement reaches zero: last wait cycle
);
  localparam int CW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n)                cnt <= '0;
    else if (load)                 cnt <= CW'(WAIT_CYC);
    else if (dec && cnt != '0)     cnt <= cnt - CW'(1);

  assign zero = (cnt <= CW'(1));
endmodule

// File: rtl/apb_slave_ws.sv
// APB4 slave front-end: wait states, byte strobes, address checks, abort on
// PSEL drop; turns each transfer into one registered register-file strobe.
module apb_slave_ws import apb_ws_pkg::*; #(
  parameter int              ADDR_W   = 12,
  parameter int              DATA_W   = 32,
  parameter int              WAIT_CYC = 0,
  parameter logic [ADDR_W-1:0] ADDR_MAX = 'h03C,
  parameter bit              ERR_EN   = 1'b1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  apb_slave_ws_if.slave        apb,
  output logic                 wr_en,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    reg_addr,
  output logic [DATA_W-1:0]    reg_wdata,
  output logic [DATA_W/8-1:0]  reg_wstrb,
  input  logic [DATA_W-1:0]    reg_rdata
);
  logic [1:0] state, state_nxt;
  logic       done, wr_q, bad_q, pready_q, pslverr_q;
  logic       start, wait_last, wr_cur, bad_cur, into_resp;

  // done holds off a restart while the master keeps penable high after completion
  assign start     = (state == ST_IDLE) && apb.tim_psel && apb.tim_penable && !done;
  assign bad_cur   = start ? addr_err(32'(apb.tim_paddr), 32'(ADDR_MAX), DATA_W) : bad_q;
  assign wr_cur    = start ? apb.tim_pwrite : wr_q;
  assign into_resp = (state_nxt == ST_RESP);

  apb_ws_counter #(.WAIT_CYC(WAIT_CYC)) u_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (start),
    .dec       (state == ST_WAIT),
    .zero      (wait_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = (WAIT_CYC > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (!apb.tim_psel)  state_nxt = ST_IDLE;
               else if (wait_last) state_nxt = ST_RESP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Response flags are registered on entry to RESP so they are clean Moore outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      done      <= 1'b0;
      wr_q      <= 1'b0;
      bad_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wstrb <= '0;
    end else begin
      state     <= state_nxt;
      pready_q  <= into_resp;
      pslverr_q <= into_resp && bad_cur && ERR_EN;
      wr_en     <= into_resp && wr_cur && !bad_cur;
      rd_en     <= into_resp && !wr_cur && !bad_cur;
      if (state == ST_RESP)      done <= 1'b1;
      else if (!apb.tim_penable) done <= 1'b0;
      if (start) begin
        wr_q      <= apb.tim_pwrite;
        bad_q     <= bad_cur;
        reg_addr  <= apb.tim_paddr & ~ADDR_W'(3);
        reg_wdata <= apb.tim_pwdata;
        reg_wstrb <= apb.tim_pwrite ? apb.tim_pstrb : '0;
      end
    end

  assign apb.tim_pready  = pready_q;
  assign apb.tim_pslverr = pslverr_q ? APB_ERR : APB_OKAY;
  assign apb.tim_prdata  = rd_en ? reg_rdata : '0;
endmodule

// File: tb/tb_apb_slave_ws.sv
// Bench for apb_slave_ws: four instances (0/3/4 wait states, ERR_EN off) fed
// from per-instance stimulus, responses checked against a queued model.
module tb_apb_slave_ws;
  localparam int AW = 12, DW = 32, SW = DW/8, ND = 4, TMO = 40;

  logic sys_clk = 1'b0, sys_rst_n = 1'b0;
  logic          psel [ND], penable [ND], pwrite [ND];
  logic [AW-1:0] paddr [ND], reg_addr [ND];
  logic [DW-1:0] pwdata [ND], reg_rdata [ND], prdata [ND], reg_wdata [ND];
  logic [SW-1:0] pstrb [ND], reg_wstrb [ND];
  logic          pready [ND], pslverr [ND], wr_en [ND], rd_en [ND];

  int checks = 0, errors = 0;

  typedef struct {
    bit wr, slverr, wen, ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, prdata;
    logic [SW-1:0] wstrb;
    int lat;
  } exp_t;
  exp_t sb [$];

  always #5 sys_clk = ~sys_clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    apb_slave_ws_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    assign bus.tim_psel    = psel[g];
    assign bus.tim_penable = penable[g];
    assign bus.tim_pwrite  = pwrite[g];
    assign bus.tim_paddr   = paddr[g];
    assign bus.tim_pwdata  = pwdata[g];
    assign bus.tim_pstrb   = pstrb[g];
    assign pready[g]  = bus.tim_pready;
    assign pslverr[g] = bus.tim_pslverr;
    assign prdata[g]  = bus.tim_prdata;
    apb_slave_ws #(
      .ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(g == 1 ? 3 : g == 2 ? 4 : 0),
      .ADDR_MAX(12'h03C), .ERR_EN(g != 3)
    ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .apb(bus),
      .wr_en(wr_en[g]), .rd_en(rd_en[g]), .reg_addr(reg_addr[g]),
      .reg_wdata(reg_wdata[g]), .reg_wstrb(reg_wstrb[g]), .reg_rdata(reg_rdata[g])
    );
  end

  function automatic int wc(input int d);
    return d == 1 ? 3 : d == 2 ? 4 : 0;
  endfunction

  function automatic exp_t model(input int d, input bit wr, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd, input logic [SW-1:0] st,
                                 input logic [DW-1:0] rd);
    exp_t e;
    bit bad;
    bad      = (a[1:0] != 2'b00) || (a > 12'h03C);
    e.wr     = wr;
    e.slverr = bad && (d != 3);
    e.wen    = wr && !bad;
    e.ren    = !wr && !bad;
    e.addr   = {a[AW-1:2], 2'b00};
    e.wdata  = wd;
    e.wstrb  = wr ? st : '0;
    e.prdata = e.ren ? rd : '0;
    e.lat    = 1 + wc(d);
    return e;
  endfunction

  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [SW-1:0] st, input logic [DW-1:0] rd, input bit hold);
    exp_t e;
    int k;
    bit seen;
    sb.push_back(model(d, wr, a, wd, st, rd));
    @(posedge sys_clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a;
    pwdata[d] = wd; pstrb[d] = st; reg_rdata[d] = rd;
    @(negedge sys_clk);
    checks++;
    if (pready[d] || wr_en[d] || rd_en[d]) begin
      errors++;
      $display("FAIL setup_quiet d%0d a=%h: pready=%b wr_en=%b rd_en=%b, want 0 0 0", d, a, pready[d], wr_en[d], rd_en[d]);
    end
    @(posedge sys_clk); #1;
    penable[d] = 1'b1;
    k = 0; seen = 1'b0;
    while (!seen && k < TMO) begin
      @(negedge sys_clk);
      if (pready[d]) seen = 1'b1;
      else begin
        checks++;
        if (wr_en[d] || rd_en[d] || pslverr[d] || prdata[d] !== '0) begin
          errors++;
          $display("FAIL pre_ready d%0d a=%h: wr_en=%b rd_en=%b pslverr=%b prdata=%h, want all 0", d, a, wr_en[d], rd_en[d], pslverr[d], prdata[d]);
        end
        k++;
      end
    end
    e = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout d%0d a=%h: pready=0 after %0d cycles, want 1 after %0d", d, a, TMO, e.lat);
    end else begin
      checks += 7;
      if (k != e.lat)            begin errors++; $display("FAIL latency d%0d a=%h: got %0d, want %0d", d, a, k, e.lat); end
      if (pslverr[d] !== e.slverr) begin errors++; $display("FAIL pslverr d%0d a=%h: got %b, want %b", d, a, pslverr[d], e.slverr); end
      if (wr_en[d] !== e.wen)    begin errors++; $display("FAIL wr_en d%0d a=%h: got %b, want %b", d, a, wr_en[d], e.wen); end
      if (rd_en[d] !== e.ren)    begin errors++; $display("FAIL rd_en d%0d a=%h: got %b, want %b", d, a, rd_en[d], e.ren); end
      if (reg_addr[d] !== e.addr) begin errors++; $display("FAIL reg_addr d%0d: got %h, want %h", d, reg_addr[d], e.addr); end
      if (reg_wstrb[d] !== e.wstrb) begin errors++; $display("FAIL reg_wstrb d%0d a=%h: got %h, want %h", d, a, reg_wstrb[d], e.wstrb); end
      if (prdata[d] !== e.prdata) begin errors++; $display("FAIL prdata d%0d a=%h: got %h, want %h", d, a, prdata[d], e.prdata); end
      if (e.wr) begin
        checks++;
        if (reg_wdata[d] !== e.wdata) begin errors++; $display("FAIL reg_wdata d%0d: got %h, want %h", d, reg_wdata[d], e.wdata); end
      end
    end
    if (hold) begin
      // master keeps penable high one more cycle: must not retrigger
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      checks++;
      if (pready[d] || wr_en[d] || rd_en[d]) begin
        errors++;
        $display("FAIL hold_dup d%0d a=%h: pready=%b wr_en=%b rd_en=%b, want 0 0 0", d, a, pready[d], wr_en[d], rd_en[d]);
      end
    end
  endtask

  task automatic idle(input int d, input int n);
    @(posedge sys_clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
    repeat (n) begin
      @(negedge sys_clk);
      checks++;
      if (pready[d] || wr_en[d] || rd_en[d] || prdata[d] !== '0) begin
        errors++;
        $display("FAIL idle_quiet d%0d: pready=%b wr_en=%b rd_en=%b prdata=%h, want 0", d, pready[d], wr_en[d], rd_en[d], prdata[d]);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < ND; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = '0;
      pwdata[d] = '0; pstrb[d] = '0; reg_rdata[d] = 32'hFFFF_FFFF;
    end
    repeat (2) @(negedge sys_clk);
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (pready[d] || pslverr[d] || wr_en[d] || rd_en[d] || reg_addr[d] !== '0 ||
          reg_wdata[d] !== '0 || reg_wstrb[d] !== '0 || prdata[d] !== '0) begin
        errors++;
        $display("FAIL reset_state d%0d: rdy=%b err=%b wr=%b rd=%b addr=%h wdata=%h wstrb=%h prdata=%h, want all 0",
                 d, pready[d], pslverr[d], wr_en[d], rd_en[d], reg_addr[d], reg_wdata[d], reg_wstrb[d], prdata[d]);
      end
    end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic test_write_ws0();
    xfer(0, 1'b1, 12'h008, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0);
    idle(0, 2);
  endtask

  task automatic test_read_ws3();
    xfer(1, 1'b0, 12'h010, 32'h0, 4'hF, 32'h1234_5678, 1'b0);
    idle(1, 2);
  endtask

  task automatic test_errors();
    xfer(0, 1'b1, 12'h040, 32'hDEAD_0001, 4'hF, 32'h0, 1'b0);
    xfer(0, 1'b0, 12'h006, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    xfer(0, 1'b0, 12'h03C, 32'h0, 4'h0, 32'h0000_003C, 1'b0);
    idle(0, 1);
    xfer(3, 1'b1, 12'h040, 32'hDEAD_0002, 4'hF, 32'h0, 1'b0);
    xfer(3, 1'b0, 12'h006, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    xfer(3, 1'b1, 12'h00C, 32'h0C0C_0C0C, 4'h5, 32'h0, 1'b0);
    idle(3, 2);
  endtask

  task automatic test_zero_strobe();
    xfer(0, 1'b1, 12'h00C, 32'h0000_FFFF, 4'h0, 32'h0, 1'b0);
    idle(0, 1);
  endtask

  task automatic test_abort();
    int hit = 0;
    @(posedge sys_clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 12'h014;
    pwdata[2] = 32'h0BAD_0BAD; pstrb[2] = 4'hF;
    @(posedge sys_clk); #1;
    penable[2] = 1'b1;
    repeat (3) @(negedge sys_clk);
    @(posedge sys_clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (8) begin
      @(negedge sys_clk);
      if (pready[2] || wr_en[2]) hit++;
    end
    checks++;
    if (hit != 0) begin errors++; $display("FAIL abort d2: %0d cycles with pready/wr_en, want 0", hit); end
    xfer(2, 1'b1, 12'h014, 32'h600D_600D, 4'hF, 32'h0, 1'b0);
    idle(2, 2);
  endtask

  task automatic test_back_to_back();
    xfer(0, 1'b1, 12'h000, 32'h1111_2222, 4'h3, 32'h0, 1'b1);
    xfer(0, 1'b0, 12'h004, 32'h0, 4'hF, 32'h3333_4444, 1'b1);
    idle(0, 2);
    xfer(1, 1'b1, 12'h020, 32'h5555_6666, 4'hC, 32'h0, 1'b0);
    xfer(1, 1'b0, 12'h024, 32'h0, 4'h0, 32'h7777_8888, 1'b0);
    idle(1, 2);
  endtask

  task automatic test_reset_mid();
    int hit = 0;
    @(posedge sys_clk); #1;
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 12'h018;
    pwdata[1] = 32'h0BAD_F00D; pstrb[1] = 4'hF;
    @(posedge sys_clk); #1;
    penable[1] = 1'b1;
    repeat (2) @(negedge sys_clk);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    #2;
    checks++;
    if (pready[1] || pslverr[1] || wr_en[1] || rd_en[1] || reg_addr[1] !== '0 ||
        reg_wdata[1] !== '0 || reg_wstrb[1] !== '0) begin
      errors++;
      $display("FAIL reset_mid d1: rdy=%b wr=%b addr=%h wdata=%h wstrb=%h, want all 0",
               pready[1], wr_en[1], reg_addr[1], reg_wdata[1], reg_wstrb[1]);
    end
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    repeat (8) begin
      @(negedge sys_clk);
      if (pready[1] || wr_en[1]) hit++;
    end
    checks++;
    if (hit != 0) begin errors++; $display("FAIL reset_mid_strobe d1: %0d cycles with pready/wr_en, want 0", hit); end
    xfer(1, 1'b0, 12'h018, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0);
    idle(1, 2);
  endtask

  initial begin
    test_reset();
    test_write_ws0();
    test_read_ws3();
    test_errors();
    test_zero_strobe();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $fatal(1);
  end
endmodule
